led_frame_capture: RTL and testbench
====================================

LED_FRAME_CAPTURE -- requirements
Module: led_frame_capture

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- shcp  input  1  shift clock from the LED matrix driver.
- stcp  input  1  storage latch strobe.
- mr  input  1  master reset, active-low; clears the shift stage.
- oe  input  1  output enable, active-low.
- ds  input  1  serial column data.
- rows_in  input  8  row drive; one-hot selects the active row.
- frame_ready  input  1  consumer accepts frame_out.
- frame_out  output  192  captured frame, row r at bits [24r+23:24r].
- frame_valid  output  1  frame_out holds a complete, stable frame.
- overflow_cnt  output  8  count of dropped frames, saturating.
- bit_err  output  1  sticky flag: a latch occurred with a shift count other than 24.

Function
REQ-003 The block SHALL pass shcp, stcp, mr, oe, ds and rows_in through a 2-flop synchronizer before use; shcp and stcp SHALL also pass through a rising-edge detector (third flop).
REQ-004 On a detected shcp rise, the block SHALL update shift_reg <= {shift_reg[22:0], ds_sync}, using the ds value synchronized in the same cycle; the first bit sent therefore ends in bit 23.
REQ-005 The block SHALL count shcp rises since the last stcp rise in a 5-bit counter (bit_cnt) that saturates at 31.
REQ-006 While mr_sync = 0, the block SHALL clear shift_reg and bit_cnt, and SHALL ignore shcp; the frame buffers SHALL be unaffected.
REQ-007 On a detected stcp rise with oe_sync = 0 and rows_in_sync exactly one-hot (bit r set), the block SHALL write shift_reg into back_buf[r] and set row_mask[r].
- A repeated row SHALL overwrite the earlier data.
- rows_in_sync zero or multi-hot, or oe_sync = 1: no write, row_mask unchanged.
REQ-008 Every stcp rise SHALL clear bit_cnt to 0, with or without a write.
REQ-009 When row_mask becomes 8'hFF, the block SHALL clear row_mask in the same cycle, and then:
- if frame_valid = 0 or frame_ready = 1 in that cycle: copy back_buf to frame_out and set frame_valid = 1 on the next clk edge;
- otherwise: drop the frame and increment overflow_cnt, saturating at 255.
REQ-010 Handshake: frame_valid and frame_out SHALL stay stable until a cycle with frame_valid = 1 and frame_ready = 1; frame_valid SHALL fall on the next edge unless a new transfer occurs in that same cycle, in which case frame_valid stays high and frame_out takes the new frame.
REQ-011 Latency: a pin-level stcp rise completing a frame SHALL produce frame_valid = 1 exactly 4 clk cycles later: 2 synchronizer stages, 1 edge stage, 1 register stage.
REQ-012 A shcp rise and an stcp rise detected in the same cycle SHALL shift first; the latched value SHALL include the new bit.
REQ-013 A new frame SHALL start in back_buf immediately after a transfer; back_buf SHALL never alias frame_out.

Reset
REQ-014 While reset_n = 0, the block SHALL clear all of the following:
- shift_reg, bit_cnt, row_mask, back_buf and the synchronizer flops;
- frame_out = 0, frame_valid = 0, overflow_cnt = 0, bit_err = 0.
REQ-015 Reset assertion mid-row or mid-handshake SHALL discard all partial and pending data; after release, capture SHALL resume with the first full stcp-bounded row.

Configuration
REQ-016 With LED_CAPTURE_BITCHECK_EN defined, bit_err SHALL set on any stcp rise where bit_cnt != 24, and SHALL clear only on reset.
REQ-017 Without LED_CAPTURE_BITCHECK_EN, bit_err SHALL be tied to 0 and the comparison logic SHALL be absent; bit_cnt MAY be removed.

Structure
REQ-018 Package led_cap_pkg SHALL hold:
- ROWS = 8, COLS = 24, BITS_PER_ROW = 24;
- typedef row_t (logic [23:0]);
- typedef frame_t (row_t [7:0]).
REQ-019 Sub-module sync_edge SHALL implement the 2-flop synchronizer plus optional rising-edge detect, with a width parameter; it SHALL be instantiated for each input.

Verification
REQ-020 Send 8 rows, row r data = 24'hA5A500 | r, each with 24 shcp pulses then stcp, oe = 0, rows_in = 1<<r, frame_ready = 1 -> frame_valid pulses once, frame_out row r = 24'hA5A500 | r, bit_err = 0.
REQ-021 Hold frame_ready = 0 and send 3 complete frames -> frame_out holds frame 1, overflow_cnt = 2; then frame_ready = 1 for one cycle -> frame_valid = 0.
REQ-022 With LED_CAPTURE_BITCHECK_EN, send 23 shcp pulses then stcp -> bit_err = 1 and stays 1; without the macro -> bit_err = 0.
REQ-023 Pulse mr low after 12 shift bits, then send 24 bits of 24'h000001 and stcp -> the row stores 24'h000001.
REQ-024 Cover the ignored-latch cases: rows_in = 8'h03, or oe = 1, during stcp -> no row written, row_mask unchanged, no frame_valid after the other 7 rows.
REQ-025 Assert reset_n = 0 after 5 rows, release it, then send 8 rows -> exactly one frame, containing only post-reset data; overflow_cnt = 0.

Source files
------------

// File: rtl/led_cap_pkg.sv
// Shared geometry, row/frame types and helpers for the LED frame capture block.
package led_cap_pkg;

  localparam int unsigned ROWS         = 8;
  localparam int unsigned COLS         = 24;
  localparam int unsigned BITS_PER_ROW = 24;

  typedef logic [BITS_PER_ROW-1:0] row_t;
  typedef row_t [ROWS-1:0]         frame_t;

  function automatic logic is_onehot(logic [ROWS-1:0] v);
    return (v != '0) && ((v & (v - ROWS'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with an optional third flop for rising-edge detection.
module sync_edge #(
  parameter int unsigned Width      = 1,
  parameter bit          EdgeDetect = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q,
  output logic [Width-1:0] rise
);

  logic [Width-1:0] ff1_q, ff2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

  if (EdgeDetect) begin : g_edge
    logic [Width-1:0] ff3_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ff3_q <= '0;
      else          ff3_q <= ff2_q;
    end
    assign rise = ff2_q & ~ff3_q;
  end else begin : g_no_edge
    assign rise = '0;
  end

endmodule

// File: rtl/led_frame_capture.sv
// Captures 74HC595-style serial LED matrix traffic into whole frames with a valid/ready output.
// Optional shift-count checking is enabled with the LED_CAPTURE_BITCHECK_EN macro.
module led_frame_capture
  import led_cap_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 shcp,
  input  logic                 stcp,
  input  logic                 mr,
  input  logic                 oe,
  input  logic                 ds,
  input  logic [ROWS-1:0]      rows_in,
  input  logic                 frame_ready,
  output logic [ROWS*COLS-1:0] frame_out,
  output logic                 frame_valid,
  output logic [7:0]           overflow_cnt,
  output logic                 bit_err
);

  logic            shcp_rise, stcp_rise, mr_s, oe_s, ds_s;
  logic [ROWS-1:0] rows_s;
  logic            unused_shcp_q, unused_stcp_q;
  logic            unused_mr_rise, unused_oe_rise, unused_ds_rise;
  logic [ROWS-1:0] unused_rows_rise;

  sync_edge #(.Width(1), .EdgeDetect(1'b1)) u_sync_shcp (
    .clk(clk), .reset_n(reset_n), .d(shcp), .q(unused_shcp_q), .rise(shcp_rise)
  );
  sync_edge #(.Width(1), .EdgeDetect(1'b1)) u_sync_stcp (
    .clk(clk), .reset_n(reset_n), .d(stcp), .q(unused_stcp_q), .rise(stcp_rise)
  );
  sync_edge #(.Width(1), .EdgeDetect(1'b0)) u_sync_mr (
    .clk(clk), .reset_n(reset_n), .d(mr), .q(mr_s), .rise(unused_mr_rise)
  );
  sync_edge #(.Width(1), .EdgeDetect(1'b0)) u_sync_oe (
    .clk(clk), .reset_n(reset_n), .d(oe), .q(oe_s), .rise(unused_oe_rise)
  );
  sync_edge #(.Width(1), .EdgeDetect(1'b0)) u_sync_ds (
    .clk(clk), .reset_n(reset_n), .d(ds), .q(ds_s), .rise(unused_ds_rise)
  );
  sync_edge #(.Width(ROWS), .EdgeDetect(1'b0)) u_sync_rows (
    .clk(clk), .reset_n(reset_n), .d(rows_in), .q(rows_s), .rise(unused_rows_rise)
  );

  row_t            shift_q, shift_d;
  frame_t          back_q, frame_q;
  logic [ROWS-1:0] row_mask_q;
  logic            valid_q;
  logic [7:0]      ovf_q;
  logic            latch_ok, frame_full, take;

  // Shift happens before latch so a coincident stcp captures the new bit.
  always_comb begin
    shift_d = shift_q;
    if (!mr_s)          shift_d = '0;
    else if (shcp_rise) shift_d = {shift_q[BITS_PER_ROW-2:0], ds_s};
  end

  assign latch_ok   = stcp_rise && !oe_s && is_onehot(rows_s);
  assign frame_full = (row_mask_q == '1);
  assign take       = frame_full && (!valid_q || frame_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      back_q     <= '0;
      row_mask_q <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= '0;
    end else begin
      shift_q    <= shift_d;
      row_mask_q <= (frame_full ? '0 : row_mask_q) | (latch_ok ? rows_s : '0);
      for (int r = 0; r < ROWS; r++) begin
        if (latch_ok && rows_s[r]) back_q[r] <= shift_d;
      end
      if (take) begin
        frame_q <= back_q;
        valid_q <= 1'b1;
      end else begin
        if (valid_q && frame_ready)           valid_q <= 1'b0;
        if (frame_full && ovf_q != 8'hFF)     ovf_q   <= ovf_q + 8'd1;
      end
    end
  end

  assign frame_out    = frame_q;
  assign frame_valid  = valid_q;
  assign overflow_cnt = ovf_q;

`ifdef LED_CAPTURE_BITCHECK_EN
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic       bit_err_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (!mr_s)                               bit_cnt_d = '0;
    else if (shcp_rise && bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
      bit_err_q <= 1'b0;
    end else if (stcp_rise) begin
      bit_cnt_q <= '0;
      if (bit_cnt_d != 5'(BITS_PER_ROW)) bit_err_q <= 1'b1;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_err = bit_err_q;
`else
  assign bit_err = 1'b0;
`endif

endmodule

// File: tb/tb_led_frame_capture.sv
// Randomized bench for led_frame_capture: a frame-level reference model feeds a scoreboard
// queue that a separate monitor drains on every valid/ready handshake.
module tb_led_frame_capture;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         shcp = 1'b0, stcp = 1'b0, mr = 1'b1, oe = 1'b0, ds = 1'b0;
  logic [7:0]   rows_in = 8'h00;
  logic         frame_ready = 1'b1;
  logic [191:0] frame_out;
  logic         frame_valid;
  logic [7:0]   overflow_cnt;
  logic         bit_err;

  led_frame_capture dut (
    .clk(clk), .reset_n(reset_n), .shcp(shcp), .stcp(stcp), .mr(mr), .oe(oe), .ds(ds),
    .rows_in(rows_in), .frame_ready(frame_ready), .frame_out(frame_out),
    .frame_valid(frame_valid), .overflow_cnt(overflow_cnt), .bit_err(bit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int exp_total = 0;

  // Reference model state: frame-level view of the serial protocol.
  logic [191:0] exp_q[$];
  logic [23:0]  m_sr = '0;
  int           m_cnt = 0;
  logic [23:0]  m_back[8];
  bit   [7:0]   m_got = '0;
  bit           m_slot_full = 0;
  int           m_ovf = 0;
  bit           m_err = 0;
  logic [191:0] m_present = '0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_sr = '0; m_cnt = 0; m_got = '0; m_slot_full = 0; m_ovf = 0; m_err = 0;
    m_present = '0;
    for (int r = 0; r < 8; r++) m_back[r] = '0;
    exp_q.delete();
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    tick(3);
    shcp = 1'b1;
    m_sr = {m_sr[22:0], b};
    if (m_cnt < 31) m_cnt++;
    tick(3);
    shcp = 1'b0;
    tick(2);
  endtask

  task automatic do_latch();
    bit           delivered;
    int           lat;
    logic [191:0] fr;
    delivered = 0;
    lat = 99;
    stcp = 1'b1;
`ifdef LED_CAPTURE_BITCHECK_EN
    if (m_cnt != 24) m_err = 1;
`endif
    m_cnt = 0;
    if (!oe && $countones(rows_in) == 1) begin
      for (int r = 0; r < 8; r++) if (rows_in[r]) begin m_back[r] = m_sr; m_got[r] = 1; end
      if (m_got == 8'hFF) begin
        m_got = '0;
        for (int r = 0; r < 8; r++) fr[24*r +: 24] = m_back[r];
        if (!m_slot_full || frame_ready) begin
          exp_q.push_back(fr);
          exp_total++;
          m_present = fr;
          m_slot_full = !frame_ready;
          delivered = 1;
        end else if (m_ovf < 255) begin
          m_ovf++;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame_valid && lat == 99) lat = i;
    end
    @(posedge clk);
    #2;
    stcp = 1'b0;
    tick(3);
    if (delivered) check("latency", 192'(lat), 192'(4));
  endtask

  task automatic send_row(input logic [23:0] data, input logic [7:0] rows, input logic oe_v,
                          input int nbits = 24);
    rows_in = rows;
    oe = oe_v;
    for (int i = nbits - 1; i >= 0; i--) shift_bit(data[i]);
    do_latch();
    oe = 1'b0;
  endtask

  task automatic send_frame_random(input bit decoys);
    int perm[8];
    int j, t;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 8; k++) begin
      if (decoys && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: send_row(24'($urandom), 8'(1 << perm[k]), 1'b1);
          1: send_row(24'($urandom), 8'(1 << perm[k]) | 8'(1 << ((perm[k] + 1) % 8)), 1'b0);
          default: if (k < 7) send_row(24'($urandom), 8'(1 << perm[k]), 1'b0);
        endcase
      end
      send_row(24'($urandom), 8'(1 << perm[k]), 1'b0);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && frame_valid && frame_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none", frame_out);
      end else begin
        check("frame_out", frame_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    int acc0;
    logic [23:0] junk;
    model_reset();
    tick(3);
    check("rst_frame_valid", 192'(frame_valid), 192'(0));
    check("rst_frame_out", frame_out, 192'(0));
    check("rst_overflow", 192'(overflow_cnt), 192'(0));
    check("rst_bit_err", 192'(bit_err), 192'(0));
    reset_n = 1'b1;
    tick(4);

    // Fixed pattern frame.
    acc0 = acc_cnt;
    for (int r = 0; r < 8; r++) send_row(24'hA5A500 | 24'(r), 8'(1 << r), 1'b0);
    tick(8);
    check("fixed_one_frame", 192'(acc_cnt - acc0), 192'(1));
    check("fixed_valid_low", 192'(frame_valid), 192'(0));
    check("fixed_bit_err", 192'(bit_err), 192'(m_err));

    // Random frames with shuffled row order, ignored latches and overwrites.
    for (int f = 0; f < 3; f++) send_frame_random(1);
    tick(8);
    check("rand_overflow", 192'(overflow_cnt), 192'(m_ovf));

    // Ignored latches: 7 rows, then multi-hot and oe=1 latches must not complete the frame.
    acc0 = acc_cnt;
    for (int r = 0; r < 7; r++) send_row(24'($urandom), 8'(1 << r), 1'b0);
    send_row(24'($urandom), 8'h03, 1'b0);
    send_row(24'($urandom), 8'h80, 1'b1);
    tick(8);
    check("ignored_no_frame", 192'(acc_cnt - acc0), 192'(0));
    check("ignored_valid_low", 192'(frame_valid), 192'(0));
    send_row(24'($urandom), 8'h80, 1'b0);
    tick(8);
    check("ignored_then_frame", 192'(acc_cnt - acc0), 192'(1));

    // Master reset mid-row clears the partial shift.
    junk = 24'($urandom);
    rows_in = 8'h01;
    for (int i = 11; i >= 0; i--) shift_bit(junk[i]);
    mr = 1'b0;
    m_sr = '0;
    m_cnt = 0;
    tick(5);
    mr = 1'b1;
    tick(4);
    send_row(24'h000001, 8'h01, 1'b0);
    for (int r = 1; r < 8; r++) send_row(24'($urandom), 8'(1 << r), 1'b0);
    tick(8);
    check("mr_row0", 192'(frame_out[23:0]), 192'(24'h000001));

    // Back-pressure: first frame held, next two dropped.
    frame_ready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame_random(0);
    tick(8);
    check("bp_valid_high", 192'(frame_valid), 192'(1));
    check("bp_frame_held", frame_out, m_present);
    check("bp_overflow", 192'(overflow_cnt), 192'(m_ovf));
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    m_slot_full = 0;
    tick(4);
    check("bp_valid_drop", 192'(frame_valid), 192'(0));
    frame_ready = 1'b1;

    // Short row: 23 shifts before the latch.
    send_row(24'($urandom), 8'h00, 1'b1, 23);
    tick(4);
    check("short_bit_err", 192'(bit_err), 192'(m_err));
    send_row(24'($urandom), 8'h00, 1'b1);
    tick(4);
    check("bit_err_sticky", 192'(bit_err), 192'(m_err));

    // Reset mid-frame and mid-row discards everything pending.
    for (int r = 0; r < 5; r++) send_row(24'($urandom), 8'(1 << r), 1'b0);
    junk = 24'($urandom);
    rows_in = 8'h20;
    for (int i = 23; i >= 14; i--) shift_bit(junk[i]);
    reset_n = 1'b0;
    model_reset();
    tick(2);
    check("mid_rst_valid", 192'(frame_valid), 192'(0));
    check("mid_rst_frame", frame_out, 192'(0));
    check("mid_rst_overflow", 192'(overflow_cnt), 192'(0));
    check("mid_rst_bit_err", 192'(bit_err), 192'(0));
    reset_n = 1'b1;
    tick(4);
    acc0 = acc_cnt;
    send_frame_random(0);
    tick(8);
    check("post_rst_one_frame", 192'(acc_cnt - acc0), 192'(1));
    check("post_rst_overflow", 192'(overflow_cnt), 192'(0));

    tick(4);
    check("scoreboard_empty", 192'(exp_q.size()), 192'(0));
    check("frames_accepted", 192'(acc_cnt), 192'(exp_total));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
